seg_scan_ctrl: RTL and testbench

Scan controller for the board's 4-digit, common-anode 7-segment display. It drives the display one digit at a time and turns a 16-bit hex value into active-low anode and cathode signals. New values are double-buffered and committed only at frame boundaries, so a value written mid-scan never shows torn digits. It sits between the pipeline CPU's debug/display register and the FPGA pins.

---
 rtl/seg_scan_ctrl_if.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle for seg_scan_ctrl: value load strobe in, scanned pins and status out.
// The master drives load/value/dp_en and the slave (the controller) drives the display outputs.
interface seg_scan_ctrl_if;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        pending;
   logic        frame_tick;

   modport master (
      output load, value, dp_en,
      input  an, seg, dp, pending, frame_tick
   );

   modport slave (
      input  load, value, dp_en,
      output an, seg, dp, pending, frame_tick
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with frame-boundary double buffering.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits 3..1).
module seg_scan_ctrl #(
   parameter int SCAN_DIV = 100000
) (
   input logic           clock,
   input logic           reset,
   seg_scan_ctrl_if.slave bus
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   // State codes equal the anode pattern of the lit digit.
   typedef enum logic [3:0] {
      DIG0 = 4'b1110,
      DIG3 = 4'b0111,
      DIG2 = 4'b1011,
      DIG1 = 4'b1101
   } digit_t;

   digit_t      digit, digit_next;
   logic [CW-1:0] cnt;
   logic        advance, boundary;
   logic [15:0] pend_value, shadow_value, shadow_value_next;
   logic [3:0]  pend_dp, shadow_dp, shadow_dp_next;
   logic        pending_q, frame_tick_q, dp_q;
   logic [3:0]  an_q, nib;
   logic [6:0]  seg_q, seg_next;
   logic [1:0]  idx_next;
   logic        dp_next;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   assign advance  = (cnt == CW'(SCAN_DIV - 1));
   assign boundary = advance && (digit == DIG1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) digit <= DIG0;
      else       digit <= digit_next;
   end

   // Scan order D0 -> D3 -> D2 -> D1; any illegal code recovers to D0.
   always_comb begin
      digit_next = digit;
      if (advance) begin
         case (digit)
            DIG0:    digit_next = DIG3;
            DIG3:    digit_next = DIG2;
            DIG2:    digit_next = DIG1;
            DIG1:    digit_next = DIG0;
            default: digit_next = DIG0;
         endcase
      end
   end

   // A load landing on the boundary edge bypasses pend and commits straight away.
   always_comb begin
      shadow_value_next = shadow_value;
      shadow_dp_next    = shadow_dp;
      if (boundary && bus.load) begin
         shadow_value_next = bus.value;
         shadow_dp_next    = bus.dp_en;
      end else if (boundary && pending_q) begin
         shadow_value_next = pend_value;
         shadow_dp_next    = pend_dp;
      end
   end

   // Outputs are decoded from next-state values so they update on the same edge as the digit.
   always_comb begin
      case (digit_next)
         DIG3:    idx_next = 2'd3;
         DIG2:    idx_next = 2'd2;
         DIG1:    idx_next = 2'd1;
         default: idx_next = 2'd0;
      endcase
      nib     = shadow_value_next[{idx_next, 2'b00} +: 4];
      dp_next = ~shadow_dp_next[idx_next];
`ifdef LEADING_ZERO_BLANK_EN
      case (idx_next)
         2'd3:    seg_next = (shadow_value_next[15:12] == 4'h0) ? 7'h7F : hex7(nib);
         2'd2:    seg_next = (shadow_value_next[15:8] == 8'h00) ? 7'h7F : hex7(nib);
         2'd1:    seg_next = (shadow_value_next[15:4] == 12'h000) ? 7'h7F : hex7(nib);
         default: seg_next = hex7(nib);
      endcase
`else
      seg_next = hex7(nib);
`endif
   end

   // Prescaler, double buffer and registered pin drivers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         pend_value   <= '0;
         pend_dp      <= '0;
         shadow_value <= '0;
         shadow_dp    <= '0;
         pending_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         an_q         <= 4'b1110;
         seg_q        <= 7'b1000000;
         dp_q         <= 1'b1;
      end else begin
         cnt          <= advance ? '0 : cnt + CW'(1);
         shadow_value <= shadow_value_next;
         shadow_dp    <= shadow_dp_next;
         if (bus.load) begin
            pend_value <= bus.value;
            pend_dp    <= bus.dp_en;
         end
         if (boundary)      pending_q <= 1'b0;
         else if (bus.load) pending_q <= 1'b1;
         frame_tick_q <= boundary;
         an_q         <= digit_next;
         seg_q        <= seg_next;
         dp_q         <= dp_next;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.pending    = pending_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl at SCAN_DIV=4: stimulus queues expected digit dwells,
// a negedge monitor pops one entry at each anode change and checks dwell length and frame_tick.
module tb_seg_scan_ctrl;

   localparam int SCAN_DIV = 4;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       tick;
   } disp_t;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   disp_t exp_q[$];

   seg_scan_ctrl_if bus();

   seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [6:0] hex_model(input logic [3:0] n);
      case (n)
         4'h0: hex_model = 7'b1000000;
         4'h1: hex_model = 7'b1111001;
         4'h2: hex_model = 7'b0100100;
         4'h3: hex_model = 7'b0110000;
         4'h4: hex_model = 7'b0011001;
         4'h5: hex_model = 7'b0010010;
         4'h6: hex_model = 7'b0000010;
         4'h7: hex_model = 7'b1111000;
         4'h8: hex_model = 7'b0000000;
         4'h9: hex_model = 7'b0010000;
         4'hA: hex_model = 7'b0001000;
         4'hB: hex_model = 7'b0000011;
         4'hC: hex_model = 7'b1000110;
         4'hD: hex_model = 7'b0100001;
         4'hE: hex_model = 7'b0000110;
         default: hex_model = 7'b0001110;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Queue one frame of expected dwells in scan order D0, D3, D2, D1.
   task automatic push_frame(input logic [15:0] v, input logic [3:0] dpe, input logic first_tick);
      int order[4];
      disp_t e;
      logic blank;
      order = '{0, 3, 2, 1};
      for (int i = 0; i < 4; i++) begin
         int k;
         k = order[i];
         blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         if (k == 3) blank = (v[15:12] == 4'h0);
         if (k == 2) blank = (v[15:8] == 8'h00);
         if (k == 1) blank = (v[15:4] == 12'h000);
`endif
         e.an   = ~(4'b0001 << k);
         e.seg  = blank ? 7'h7F : hex_model(v[4*k +: 4]);
         e.dp   = ~dpe[k];
         e.tick = (k == 0) ? first_tick : 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_an(input logic [3:0] target);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(posedge clock);
         #1;
         if (bus.an == target) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_an: timeout got %b expected %b", bus.an, target);
      end
   endtask

   task automatic wait_commit();
      logic found;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(posedge clock);
         #1;
         if (!bus.pending) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_commit: timeout pending still %b", bus.pending);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dpe);
      bus.load  = 1'b1;
      bus.value = v;
      bus.dp_en = dpe;
      @(posedge clock);
      #1;
      bus.load  = 1'b0;
   endtask

   // Monitor: one queue entry per anode change, plus dwell and frame_tick checks every cycle.
   logic [3:0] last_an;
   logic       fresh;
   int         dwell;
   initial begin
      fresh = 1'b1;
      dwell = 0;
      last_an = 4'b0000;
   end

   always @(negedge clock) begin
      disp_t e;
      logic changed;
      if (reset) begin
         fresh = 1'b1;
         dwell = 0;
      end else begin
         changed = fresh || (bus.an != last_an);
         if (changed) begin
            if (!fresh) checkOutput("dwell", 16'(dwell), 16'(SCAN_DIV));
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL scoreboard: unexpected digit an=%b seg=%b", bus.an, bus.seg);
            end else begin
               e = exp_q.pop_front();
               checkOutput("an", 16'(bus.an), 16'(e.an));
               checkOutput("seg", 16'(bus.seg), 16'(e.seg));
               checkOutput("dp", 16'(bus.dp), 16'(e.dp));
               checkOutput("frame_tick", 16'(bus.frame_tick), 16'(e.tick));
            end
            dwell = 1;
            last_an = bus.an;
            fresh = 1'b0;
         end else begin
            dwell++;
            checkOutput("frame_tick_idle", 16'(bus.frame_tick), 16'd0);
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      bus.load  = 1'b0;
      bus.value = 16'h0000;
      bus.dp_en = 4'b0000;
      push_frame(16'h0000, 4'b0000, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_an", 16'(bus.an), 16'(4'b1110));
      checkOutput("rst_seg", 16'(bus.seg), 16'(7'b1000000));
      checkOutput("rst_dp", 16'(bus.dp), 16'd1);
      checkOutput("rst_pending", 16'(bus.pending), 16'd0);
      applyStimulus(16'hFFFF, 4'b1111);
      checkOutput("rst_load_ignored", 16'(bus.pending), 16'd0);
      reset = 1'b0;

      // 12AF with dp on D1, loaded mid-D3.
      wait_an(4'b0111);
      push_frame(16'h12AF, 4'b0010, 1'b1);
      applyStimulus(16'h12AF, 4'b0010);
      checkOutput("pending_set", 16'(bus.pending), 16'd1);
      checkOutput("an_held", 16'(bus.an), 16'(4'b0111));
      checkOutput("seg_held", 16'(bus.seg), 16'(7'b1000000));
      wait_commit();
      checkOutput("commit_an", 16'(bus.an), 16'(4'b1110));
      checkOutput("commit_seg_F", 16'(bus.seg), 16'(7'b0001110));

      // Two loads in one frame: only the last reaches the display.
      push_frame(16'h2222, 4'b0000, 1'b1);
      wait_an(4'b0111);
      applyStimulus(16'h1111, 4'b0000);
      wait_an(4'b1011);
      applyStimulus(16'h2222, 4'b0000);
      wait_commit();

      // Load landing on the boundary edge itself.
      push_frame(16'h00C3, 4'b0000, 1'b1);
      wait_an(4'b1101);
      repeat (SCAN_DIV - 1) @(posedge clock);
      #1;
      applyStimulus(16'h00C3, 4'b0000);
      checkOutput("bypass_pending", 16'(bus.pending), 16'd0);
      checkOutput("bypass_an", 16'(bus.an), 16'(4'b1110));
      checkOutput("bypass_seg_3", 16'(bus.seg), 16'(7'b0110000));

      // Asynchronous reset during D2 with a load outstanding.
      wait_an(4'b0111);
      applyStimulus(16'hBEEF, 4'b1111);
      checkOutput("pending_before_rst", 16'(bus.pending), 16'd1);
      wait_an(4'b1011);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_an", 16'(bus.an), 16'(4'b1110));
      checkOutput("async_seg", 16'(bus.seg), 16'(7'b1000000));
      checkOutput("async_pending", 16'(bus.pending), 16'd0);
      exp_q.delete();
      push_frame(16'h0000, 4'b0000, 1'b0);
      push_frame(16'h0000, 4'b0000, 1'b1);
      @(posedge clock);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clock);
      checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
      repeat (2) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
